// File: rtl/fme_pkg.sv
// Shared types and helpers for the FME SAD / best-candidate datapath.
// Lane count, width derivation and flat-bus lane slicing.
package fme_pkg;

    localparam int LANES = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Row sum of LANES abs diffs needs 4 extra bits, ROWS adds clog2(ROWS).
    function automatic int sad_width(input int dw, input int rows);
        return dw + 2 + 4 + clog2(rows);
    endfunction

    function automatic int lane_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/fme_absdiff_lane.sv
// One lane: signed candidate minus zero-extended original, then magnitude.
// |d| never exceeds 767, so the magnitude fits DATA_WIDTH+2 bits.
module fme_absdiff_lane
    import fme_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH+1:0] i_cand,
    input  logic [DATA_WIDTH-1:0] i_orig,
    output logic [DATA_WIDTH+1:0] o_abs
);

    logic [DATA_WIDTH+2:0] w_diff;

    assign w_diff = {i_cand[DATA_WIDTH+1], i_cand} - {3'b000, i_orig};

    // Low bits of -d equal ~d+1 truncated; the magnitude fits, so no MSB needed.
    assign o_abs = w_diff[DATA_WIDTH+2]
                 ? (~w_diff[DATA_WIDTH+1:0] + {{(DATA_WIDTH+1){1'b0}}, 1'b1})
                 : w_diff[DATA_WIDTH+1:0];

endmodule

// File: rtl/fme_sad_best_select.sv
// Pipelined row SAD, per-candidate accumulation and minimum-SAD tracking
// over one search; reports the winning candidate id.
module fme_sad_best_select
    import fme_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 16,
    parameter int ID_W       = 4,
    localparam int SAD_W     = sad_width(DATA_WIDTH, ROWS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic                            in_first,
    input  logic                            in_last,
    input  logic                            in_last_cand,
    input  logic [ID_W-1:0]                 cand_id,
    input  logic [LANES*(DATA_WIDTH+2)-1:0] cand_flat,
    input  logic [LANES*DATA_WIDTH-1:0]     orig_flat,
    output logic                            sad_valid,
    output logic [SAD_W-1:0]                sad_out,
    output logic [ID_W-1:0]                 sad_id,
    output logic                            best_valid,
    output logic [SAD_W-1:0]                best_sad,
    output logic [ID_W-1:0]                 best_id,
    output logic                            row_err
);

    localparam int CW    = DATA_WIDTH + 2;
    localparam int PW    = DATA_WIDTH + 4;
    localparam int RW    = DATA_WIDTH + 6;
    localparam int CNT_W = clog2(ROWS) + 2;

    logic [CW-1:0]    w_abs [LANES];
    logic [CW-1:0]    r_s1_abs [LANES];
    logic             r_s1_valid, r_s1_first, r_s1_last, r_s1_lc;
    logic [ID_W-1:0]  r_s1_id;
    logic [PW-1:0]    r_s2_part [4];
    logic             r_s2_valid, r_s2_first, r_s2_last, r_s2_lc;
    logic [ID_W-1:0]  r_s2_id;
    logic [RW-1:0]    w_rowsum;
    logic [SAD_W-1:0] w_acc_next, r_acc;
    logic [CNT_W-1:0] w_cnt_now, r_cnt;
    logic             r_row_err;
    logic             r_sad_valid, r_sad_lc;
    logic [SAD_W-1:0] r_sad_out;
    logic [ID_W-1:0]  r_sad_id;
    logic             w_best_win;
    logic [SAD_W-1:0] r_best_sad, r_bs;
    logic [ID_W-1:0]  r_best_id, r_bi;
    logic             r_bv;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        fme_absdiff_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .i_cand (cand_flat[lane_lsb(k, CW) +: CW]),
            .i_orig (orig_flat[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
            .o_abs  (w_abs[k])
        );
    end

    always_comb begin
        w_rowsum   = RW'(r_s2_part[0]) + RW'(r_s2_part[1])
                   + RW'(r_s2_part[2]) + RW'(r_s2_part[3]);
        w_acc_next = (r_s2_first ? '0 : r_acc) + SAD_W'(w_rowsum);
        w_cnt_now  = in_first ? CNT_W'(1) : r_cnt + CNT_W'(1);
        w_best_win = r_sad_out < r_best_sad;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_lc    <= 1'b0;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_lc    <= 1'b0;
            r_s2_id    <= '0;
            for (int k = 0; k < LANES; k++) r_s1_abs[k] <= '0;
            for (int p = 0; p < 4; p++) r_s2_part[p] <= '0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_first <= in_first;
                r_s1_last  <= in_last;
                r_s1_lc    <= in_last_cand;
                r_s1_id    <= cand_id;
                for (int k = 0; k < LANES; k++) r_s1_abs[k] <= w_abs[k];
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_first <= r_s1_first;
                r_s2_last  <= r_s1_last;
                r_s2_lc    <= r_s1_lc;
                r_s2_id    <= r_s1_id;
                for (int p = 0; p < 4; p++) begin
                    r_s2_part[p] <= PW'(r_s1_abs[4*p])   + PW'(r_s1_abs[4*p+1])
                                  + PW'(r_s1_abs[4*p+2]) + PW'(r_s1_abs[4*p+3]);
                end
            end
        end
    end

    // The accumulator is cleared after a last row so a stray non-first row starts from 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_sad_valid <= 1'b0;
            r_sad_out   <= '0;
            r_sad_id    <= '0;
            r_sad_lc    <= 1'b0;
        end else begin
            r_sad_valid <= r_s2_valid && r_s2_last;
            if (r_s2_valid) begin
                r_acc <= r_s2_last ? '0 : w_acc_next;
                if (r_s2_last) begin
                    r_sad_out <= w_acc_next;
                    r_sad_id  <= r_s2_id;
                    r_sad_lc  <= r_s2_lc;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_row_err <= 1'b0;
        end else if (in_valid) begin
            if (in_last) begin
                r_cnt <= '0;
                if (w_cnt_now != CNT_W'(ROWS)) r_row_err <= 1'b1;
            end else begin
                r_cnt <= w_cnt_now;
            end
        end
    end

    // Strict compare keeps the earlier candidate on ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_best_sad <= '1;
            r_best_id  <= '0;
            r_bv       <= 1'b0;
            r_bs       <= '0;
            r_bi       <= '0;
        end else begin
            r_bv <= 1'b0;
            if (r_sad_valid) begin
                if (r_sad_lc) begin
                    r_bv       <= 1'b1;
                    r_bs       <= w_best_win ? r_sad_out : r_best_sad;
                    r_bi       <= w_best_win ? r_sad_id : r_best_id;
                    r_best_sad <= '1;
                    r_best_id  <= '0;
                end else if (w_best_win) begin
                    r_best_sad <= r_sad_out;
                    r_best_id  <= r_sad_id;
                end
            end
        end
    end

    assign sad_valid  = r_sad_valid;
    assign sad_out    = r_sad_out;
    assign sad_id     = r_sad_id;
    assign best_valid = r_bv;
    assign best_sad   = r_bs;
    assign best_id    = r_bi;
    assign row_err    = r_row_err;

endmodule

// File: tb/tb_fme_sad_best_select.sv
// Directed bench for fme_sad_best_select at ROWS=4 (SAD_W=16).
// A negedge monitor logs output pulses with cycle stamps for the tests.
module tb_fme_sad_best_select;

    localparam int DW = 8;
    localparam int RWS = 4;
    localparam int IW = 4;
    localparam int SW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_first = 1'b0;
    logic            in_last = 1'b0;
    logic            in_last_cand = 1'b0;
    logic [IW-1:0]   cand_id = '0;
    logic [16*10-1:0] cand_flat = '0;
    logic [16*8-1:0]  orig_flat = '0;
    logic            sad_valid, best_valid, row_err;
    logic [SW-1:0]   sad_out, best_sad;
    logic [IW-1:0]   sad_id, best_id;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int t_last = 0;
    int t_first = 0;
    int sq_cyc[$], sq_sad[$], sq_id[$];
    int bq_cyc[$], bq_sad[$], bq_id[$];

    fme_sad_best_select #(.DATA_WIDTH(DW), .ROWS(RWS), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .in_last_cand(in_last_cand), .cand_id(cand_id),
        .cand_flat(cand_flat), .orig_flat(orig_flat),
        .sad_valid(sad_valid), .sad_out(sad_out), .sad_id(sad_id),
        .best_valid(best_valid), .best_sad(best_sad), .best_id(best_id),
        .row_err(row_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sad_valid) begin
            sq_cyc.push_back(cyc);
            sq_sad.push_back(int'(sad_out));
            sq_id.push_back(int'(sad_id));
        end
        if (best_valid) begin
            bq_cyc.push_back(cyc);
            bq_sad.push_back(int'(best_sad));
            bq_id.push_back(int'(best_id));
        end
    end

    task automatic clear_q();
        sq_cyc.delete(); sq_sad.delete(); sq_id.delete();
        bq_cyc.delete(); bq_sad.delete(); bq_id.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 0; in_first = 0; in_last = 0; in_last_cand = 0;
        end
    endtask

    // Lane 0 gets c0, lanes 1..15 get cr; all originals are o.
    task automatic row(input logic [9:0] c0, input logic [9:0] cr,
                       input logic [7:0] o, input logic f, input logic l,
                       input logic lc, input logic [IW-1:0] id);
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            cand_flat[k*10 +: 10] = (k == 0) ? c0 : cr;
            orig_flat[k*8 +: 8]   = o;
        end
        in_valid = 1; in_first = f; in_last = l; in_last_cand = lc;
        cand_id = id;
        if (f) t_first = cyc;
        if (l) t_last = cyc;
    endtask

    task automatic block(input logic [9:0] c0, input logic [9:0] cr,
                         input logic [7:0] o, input logic [IW-1:0] id,
                         input logic lc, input int nrows,
                         input int gap_at, input int gap_len);
        for (int r = 0; r < nrows; r++) begin
            if (r == gap_at) idle(gap_len);
            row(c0, cr, o, r == 0, r == nrows - 1, lc && (r == nrows - 1), id);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        nchk++;
        if ({sad_valid, best_valid, row_err} !== 3'b000) begin
            nerr++;
            $display("FAIL reset_flags got %b want 000", {sad_valid, best_valid, row_err});
        end
        nchk++;
        if (sad_out !== '0 || sad_id !== '0) begin
            nerr++;
            $display("FAIL reset_sad got %0d/%0d want 0/0", sad_out, sad_id);
        end
        nchk++;
        if (best_sad !== '0 || best_id !== '0) begin
            nerr++;
            $display("FAIL reset_best got %0d/%0d want 0/0", best_sad, best_id);
        end
        rst = 0;
        idle(2);
    endtask

    task automatic test_basic();
        int ts;
        clear_q();
        block(10'd10, 10'd10, 8'd7, 4'd0, 1'b1, 4, -1, 0);
        ts = t_last;
        idle(6);
        nchk++;
        if (sq_sad.size() != 1 || bq_sad.size() != 1) begin
            nerr++;
            $display("FAIL basic_count got %0d/%0d pulses want 1/1", sq_sad.size(), bq_sad.size());
        end else begin
            nchk++;
            if (sq_cyc[0] - ts != 3 || sq_sad[0] != 192 || sq_id[0] != 0) begin
                nerr++;
                $display("FAIL basic_sad got lat %0d sad %0d id %0d want 3 192 0",
                         sq_cyc[0] - ts, sq_sad[0], sq_id[0]);
            end
            nchk++;
            if (bq_cyc[0] - ts != 4 || bq_sad[0] != 192 || bq_id[0] != 0) begin
                nerr++;
                $display("FAIL basic_best got lat %0d sad %0d id %0d want 4 192 0",
                         bq_cyc[0] - ts, bq_sad[0], bq_id[0]);
            end
        end
        nchk++;
        if (row_err !== 1'b0) begin
            nerr++;
            $display("FAIL basic_rowerr got %b want 0", row_err);
        end
    endtask

    task automatic test_extremes();
        clear_q();
        block(10'h200, 10'h200, 8'd255, 4'd5, 1'b1, 4, -1, 0);
        block(10'h1FF, 10'h1FF, 8'd0, 4'd6, 1'b1, 4, -1, 0);
        idle(6);
        nchk++;
        if (sq_sad.size() != 2 || bq_sad.size() != 2) begin
            nerr++;
            $display("FAIL ext_count got %0d/%0d want 2/2", sq_sad.size(), bq_sad.size());
        end else begin
            nchk++;
            if (sq_sad[0] != 49088 || sq_id[0] != 5) begin
                nerr++;
                $display("FAIL ext_neg got %0d id %0d want 49088 id 5", sq_sad[0], sq_id[0]);
            end
            nchk++;
            if (sq_sad[1] != 32704 || sq_id[1] != 6) begin
                nerr++;
                $display("FAIL ext_pos got %0d id %0d want 32704 id 6", sq_sad[1], sq_id[1]);
            end
            nchk++;
            if (bq_sad[0] != 49088 || bq_id[0] != 5 || bq_sad[1] != 32704 || bq_id[1] != 6) begin
                nerr++;
                $display("FAIL ext_best got %0d/%0d %0d/%0d want 49088/5 32704/6",
                         bq_sad[0], bq_id[0], bq_sad[1], bq_id[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t3;
        int exp_sad[5] = '{300, 200, 200, 400, 500};
        int exp_id[5]  = '{0, 1, 2, 3, 7};
        clear_q();
        block(10'd75, 10'd0, 8'd0, 4'd0, 1'b0, 4, -1, 0);
        block(10'd50, 10'd0, 8'd0, 4'd1, 1'b0, 4, -1, 0);
        block(10'd50, 10'd0, 8'd0, 4'd2, 1'b0, 4, -1, 0);
        block(10'd100, 10'd0, 8'd0, 4'd3, 1'b1, 4, -1, 0);
        t3 = t_last;
        block(10'd125, 10'd0, 8'd0, 4'd7, 1'b1, 4, -1, 0);
        idle(6);
        nchk++;
        if (sq_sad.size() != 5 || bq_sad.size() != 2) begin
            nerr++;
            $display("FAIL b2b_count got %0d/%0d want 5/2", sq_sad.size(), bq_sad.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                nchk++;
                if (sq_sad[i] != exp_sad[i] || sq_id[i] != exp_id[i]) begin
                    nerr++;
                    $display("FAIL b2b_sad%0d got %0d id %0d want %0d id %0d",
                             i, sq_sad[i], sq_id[i], exp_sad[i], exp_id[i]);
                end
            end
            nchk++;
            if (bq_cyc[0] - t3 != 4 || bq_sad[0] != 200 || bq_id[0] != 1) begin
                nerr++;
                $display("FAIL b2b_tie got lat %0d sad %0d id %0d want 4 200 1",
                         bq_cyc[0] - t3, bq_sad[0], bq_id[0]);
            end
            nchk++;
            if (bq_sad[1] != 500 || bq_id[1] != 7) begin
                nerr++;
                $display("FAIL b2b_newsearch got %0d id %0d want 500 id 7", bq_sad[1], bq_id[1]);
            end
        end
    endtask

    task automatic test_gap();
        clear_q();
        block(10'd10, 10'd10, 8'd7, 4'd2, 1'b1, 4, 2, 3);
        idle(6);
        nchk++;
        if (t_last - t_first != 6) begin
            nerr++;
            $display("FAIL gap_span got %0d want 6", t_last - t_first);
        end
        nchk++;
        if (sq_sad.size() != 1 || bq_sad.size() != 1) begin
            nerr++;
            $display("FAIL gap_count got %0d/%0d want 1/1", sq_sad.size(), bq_sad.size());
        end else begin
            nchk++;
            if (sq_cyc[0] - t_first != 9 || sq_sad[0] != 192 || sq_id[0] != 2) begin
                nerr++;
                $display("FAIL gap_sad got at %0d sad %0d id %0d want 9 192 2",
                         sq_cyc[0] - t_first, sq_sad[0], sq_id[0]);
            end
            nchk++;
            if (bq_sad[0] != 192 || bq_id[0] != 2) begin
                nerr++;
                $display("FAIL gap_best got %0d id %0d want 192 id 2", bq_sad[0], bq_id[0]);
            end
        end
    endtask

    task automatic test_row_err();
        clear_q();
        block(10'd10, 10'd10, 8'd7, 4'd4, 1'b1, 3, -1, 0);
        idle(6);
        nchk++;
        if (row_err !== 1'b1) begin
            nerr++;
            $display("FAIL rowerr_set got %b want 1", row_err);
        end
        nchk++;
        if (sq_sad.size() != 1 || sq_sad[0] != 144 || sq_id[0] != 4) begin
            nerr++;
            $display("FAIL rowerr_sad got n=%0d want one pulse 144 id 4", sq_sad.size());
        end
        block(10'd10, 10'd10, 8'd7, 4'd5, 1'b1, 4, -1, 0);
        idle(6);
        nchk++;
        if (row_err !== 1'b1) begin
            nerr++;
            $display("FAIL rowerr_sticky got %b want 1", row_err);
        end
        nchk++;
        if (sq_sad.size() != 2 || sq_sad[1] != 192) begin
            nerr++;
            $display("FAIL rowerr_next got n=%0d want 2 pulses, second 192", sq_sad.size());
        end
    endtask

    task automatic test_mid_reset();
        clear_q();
        row(10'd30, 10'd30, 8'd7, 1'b1, 1'b0, 1'b0, 4'd8);
        row(10'd30, 10'd30, 8'd7, 1'b0, 1'b0, 1'b0, 4'd8);
        row(10'd30, 10'd30, 8'd7, 1'b0, 1'b0, 1'b0, 4'd8);
        @(negedge clk);
        in_valid = 0;
        rst = 1;
        #1;
        nchk++;
        if ({sad_valid, best_valid, row_err} !== 3'b000 || sad_out !== '0 || best_sad !== '0) begin
            nerr++;
            $display("FAIL midrst_outputs got v%b bv%b e%b sad %0d best %0d want all 0",
                     sad_valid, best_valid, row_err, sad_out, best_sad);
        end
        idle(2);
        rst = 0;
        block(10'd20, 10'd20, 8'd7, 4'd9, 1'b1, 4, -1, 0);
        idle(6);
        nchk++;
        if (sq_sad.size() != 1 || bq_sad.size() != 1) begin
            nerr++;
            $display("FAIL midrst_count got %0d/%0d want 1/1", sq_sad.size(), bq_sad.size());
        end else begin
            nchk++;
            if (sq_sad[0] != 832 || sq_id[0] != 9 || bq_sad[0] != 832 || bq_id[0] != 9) begin
                nerr++;
                $display("FAIL midrst_sad got %0d/%0d best %0d/%0d want 832/9",
                         sq_sad[0], sq_id[0], bq_sad[0], bq_id[0]);
            end
        end
        nchk++;
        if (row_err !== 1'b0) begin
            nerr++;
            $display("FAIL midrst_rowerr got %b want 0", row_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_back_to_back();
        test_gap();
        test_row_err();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
